// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one 128-bit line memory port between I-cache (port 0)
// and D-cache (port 1); one transaction in flight, command latched at grant.
module mem_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 0,
    parameter int TO_BITS       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         m0_req,
    input  logic         m1_req,
    input  logic         m0_we,
    input  logic         m1_we,
    input  logic [31:0]  m0_addr,
    input  logic [31:0]  m1_addr,
    input  logic [127:0] m0_wdata,
    input  logic [127:0] m1_wdata,
    output logic [127:0] m0_rdata,
    output logic [127:0] m1_rdata,
    output logic         m0_ready,
    output logic         m1_ready,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic         grant_id,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TO_BITS-1:0] TO_LIM = TO_BITS'(TIMEOUT);
    localparam logic [TO_BITS-1:0] TO_ONE = {{(TO_BITS-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 grant_s;
    logic                 winner_s;
    logic                 busy_s;
    logic                 hit_s;
    logic                 grant_id_r;
    logic                 last_grant_r;
    logic                 mem_req_r;
    logic                 mem_we_r;
    logic [31:0]          mem_addr_r;
    logic [127:0]         mem_wdata_r;
    logic [TO_BITS-1:0]   to_cnt_r;
    logic [TO_BITS-1:0]   to_cnt_inc_s;
    logic                 timeout_err_r;

    // Round-robin alternates away from the last owner; fixed mode favours the D-cache.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        logic w;
        if (r0 && r1) begin
            if (PRIORITY_MODE == 1) begin
                w = 1'b1;
            end else begin
                w = ~last;
            end
        end else if (r1) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

    // Next-state decode and grant strobe.
    always_comb begin
        state_nxt_s  = state_r;
        grant_s      = 1'b0;
        winner_s     = pick_winner(m0_req, m1_req, last_grant_r);
        to_cnt_inc_s = (&to_cnt_r) ? to_cnt_r : (to_cnt_r + TO_ONE);
        hit_s        = (TIMEOUT != 0) && (to_cnt_inc_s >= TO_LIM);
        case (state_r)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt_s = BUSY;
                    grant_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, timeout counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            mem_req_r     <= 1'b0;
            grant_id_r    <= 1'b0;
            last_grant_r  <= 1'b0;
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                mem_req_r    <= 1'b1;
                grant_id_r   <= winner_s;
                last_grant_r <= winner_s;
                to_cnt_r     <= '0;
            end else if (state_r == BUSY) begin
                to_cnt_r <= to_cnt_inc_s;
                if (mem_ready) begin
                    mem_req_r <= 1'b0;
                end else begin
                    mem_req_r <= 1'b1;
                end
                if (hit_s) begin
                    timeout_err_r <= 1'b1;
                end else begin
                    timeout_err_r <= timeout_err_r;
                end
            end else begin
                mem_req_r <= 1'b0;
            end
        end
    end

    // Downstream command is captured once at grant and held through BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= '0;
        end else if (grant_s) begin
            mem_we_r    <= winner_s ? m1_we    : m0_we;
            mem_addr_r  <= winner_s ? m1_addr  : m0_addr;
            mem_wdata_r <= winner_s ? m1_wdata : m0_wdata;
        end else begin
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    assign busy_s      = (state_r == BUSY);
    assign busy        = busy_s;
    assign grant_id    = grant_id_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign timeout_err = timeout_err_r;

    // Completion is passed straight through to the owner only, with no added latency.
    assign m0_ready = mem_ready & busy_s & ~grant_id_r;
    assign m1_ready = mem_ready & busy_s &  grant_id_r;
    assign m0_rdata = (busy_s && !grant_id_r) ? mem_rdata : '0;
    assign m1_rdata = (busy_s &&  grant_id_r) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: round-robin/timeout instance and fixed-priority instance
// share stimulus; sel picks which one is observed.
module tb_mem_arbiter;

    typedef struct {
        logic         port;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    logic m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [127:0] m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;
    logic mem_ready = 1'b0;

    logic [127:0] d0_m0_rdata, d0_m1_rdata, d0_mem_wdata, d1_m0_rdata, d1_m1_rdata, d1_mem_wdata;
    logic [31:0]  d0_mem_addr, d1_mem_addr;
    logic d0_m0_ready, d0_m1_ready, d0_mem_req, d0_mem_we, d0_grant_id, d0_busy, d0_terr;
    logic d1_m0_ready, d1_m1_ready, d1_mem_req, d1_mem_we, d1_grant_id, d1_busy, d1_terr;

    logic [127:0] o_m0_rdata, o_m1_rdata, o_mem_wdata;
    logic [31:0]  o_mem_addr;
    logic o_m0_ready, o_m1_ready, o_mem_req, o_mem_we, o_grant_id, o_busy, o_terr;

    int chk_cnt = 0;
    int err_cnt = 0;
    txn_t exp_q[$];
    logic prev_req = 1'b0;

    mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(8), .TO_BITS(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(d0_m0_rdata), .m1_rdata(d0_m1_rdata), .m0_ready(d0_m0_ready), .m1_ready(d0_m1_ready),
        .mem_req(d0_mem_req), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_id(d0_grant_id), .busy(d0_busy), .timeout_err(d0_terr)
    );

    mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(0), .TO_BITS(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(d1_m0_rdata), .m1_rdata(d1_m1_rdata), .m0_ready(d1_m0_ready), .m1_ready(d1_m1_ready),
        .mem_req(d1_mem_req), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_id(d1_grant_id), .busy(d1_busy), .timeout_err(d1_terr)
    );

    assign o_m0_rdata  = sel ? d1_m0_rdata  : d0_m0_rdata;
    assign o_m1_rdata  = sel ? d1_m1_rdata  : d0_m1_rdata;
    assign o_m0_ready  = sel ? d1_m0_ready  : d0_m0_ready;
    assign o_m1_ready  = sel ? d1_m1_ready  : d0_m1_ready;
    assign o_mem_req   = sel ? d1_mem_req   : d0_mem_req;
    assign o_mem_we    = sel ? d1_mem_we    : d0_mem_we;
    assign o_mem_addr  = sel ? d1_mem_addr  : d0_mem_addr;
    assign o_mem_wdata = sel ? d1_mem_wdata : d0_mem_wdata;
    assign o_grant_id  = sel ? d1_grant_id  : d0_grant_id;
    assign o_busy      = sel ? d1_busy      : d0_busy;
    assign o_terr      = sel ? d1_terr      : d0_terr;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic port, input logic we, input logic [31:0] addr,
                            input logic [127:0] wdata, input logic [127:0] rdata);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    // Wait for the downstream request, answer after lat cycles, retire the owner's request.
    task automatic serve(input int lat, input logic [127:0] data);
        int n;
        logic g;
        n = 0;
        while (!o_mem_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("serve_wait", 128'(o_mem_req), 128'(1'b1));
        repeat (lat) tick();
        mem_ready = 1'b1;
        mem_rdata = data;
        #1;
        g = o_grant_id;
        check_eq("ready_owner", 128'(g ? o_m1_ready : o_m0_ready), 128'(1'b1));
        check_eq("ready_other", 128'(g ? o_m0_ready : o_m1_ready), 128'(1'b0));
        check_eq("rdata_other", g ? o_m0_rdata : o_m1_rdata, '0);
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (g) m1_req = 1'b0; else m0_req = 1'b0;
        #1;
        check_eq("memreq_low_after", 128'(o_mem_req), 128'(1'b0));
        check_eq("busy_low_after", 128'(o_busy), 128'(1'b0));
    endtask

    // Scoreboard monitor: command checked at each new grant, response checked and retired at ready.
    always @(negedge clk) begin
        txn_t t;
        if (o_mem_req && !prev_req) begin
            check_eq("start_expected", 128'(exp_q.size() > 0), 128'(1'b1));
            if (exp_q.size() > 0) begin
                check_eq("grant_id", 128'(o_grant_id), 128'(exp_q[0].port));
                check_eq("mem_we", 128'(o_mem_we), 128'(exp_q[0].we));
                check_eq("mem_addr", 128'(o_mem_addr), 128'(exp_q[0].addr));
                check_eq("mem_wdata", o_mem_wdata, exp_q[0].wdata);
            end
        end
        if (o_m0_ready || o_m1_ready) begin
            check_eq("ready_expected", 128'(exp_q.size() > 0), 128'(1'b1));
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                check_eq("ready_port", 128'(o_m1_ready), 128'(t.port));
                check_eq("rdata", t.port ? o_m1_rdata : o_m0_rdata, t.rdata);
            end
        end
        prev_req <= o_mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a5;
        a5 = {4{32'hA5A5_A5A5}};

        // reset state
        repeat (2) tick();
        check_eq("rst_mem_req", 128'(o_mem_req), 128'(1'b0));
        check_eq("rst_busy", 128'(o_busy), 128'(1'b0));
        check_eq("rst_terr", 128'(o_terr), 128'(1'b0));
        check_eq("rst_mem_addr", 128'(o_mem_addr), 128'(32'h0));
        check_eq("rst_m0_rdata", o_m0_rdata, '0);
        rst_n = 1'b1;
        tick();

        // single read on port 0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1230;
        push_txn(1'b0, 1'b0, 32'h0000_1230, '0, a5);
        tick();
        check_eq("t1_mem_req", 128'(o_mem_req), 128'(1'b1));
        check_eq("t1_mem_addr", 128'(o_mem_addr), 128'(32'h0000_1230));
        serve(3, a5);

        // simultaneous requests, round-robin after reset: port 1, then port 0, then port 1
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0200; m1_wdata = {4{32'h1111_2222}};
        push_txn(1'b1, 1'b1, 32'h0000_0200, {4{32'h1111_2222}}, {4{32'h0BAD_0001}});
        push_txn(1'b0, 1'b0, 32'h0000_0100, '0, {4{32'h0BAD_0002}});
        serve(1, {4{32'h0BAD_0001}});
        tick();
        check_eq("rr_rerise", 128'(o_mem_req), 128'(1'b1));
        check_eq("rr_second_grant", 128'(o_grant_id), 128'(1'b0));
        serve(2, {4{32'h0BAD_0002}});
        m0_req = 1'b1; m0_addr = 32'h0000_0110;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0210;
        push_txn(1'b1, 1'b0, 32'h0000_0210, {4{32'h1111_2222}}, {4{32'h0BAD_0003}});
        push_txn(1'b0, 1'b0, 32'h0000_0110, '0, {4{32'h0BAD_0004}});
        tick();
        check_eq("rr_third_grant", 128'(o_grant_id), 128'(1'b1));
        serve(1, {4{32'h0BAD_0003}});
        serve(1, {4{32'h0BAD_0004}});

        // D-cache writeback then refill
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0400; m1_wdata = {4{32'hDEAD_BEEF}};
        push_txn(1'b1, 1'b1, 32'h0000_0400, {4{32'hDEAD_BEEF}}, '0);
        serve(2, '0);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0800; m1_wdata = '0;
        push_txn(1'b1, 1'b0, 32'h0000_0800, '0, {4{32'h5555_AAAA}});
        serve(2, {4{32'h5555_AAAA}});

        // reset in the middle of a transaction
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1230;
        push_txn(1'b0, 1'b0, 32'h0000_1230, '0, a5);
        repeat (3) tick();
        check_eq("mid_busy", 128'(o_busy), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_mem_req", 128'(o_mem_req), 128'(1'b0));
        check_eq("mid_rst_busy", 128'(o_busy), 128'(1'b0));
        m0_req = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        mem_ready = 1'b1; mem_rdata = a5;
        #1;
        check_eq("stale_m0_ready", 128'(o_m0_ready), 128'(1'b0));
        check_eq("stale_m1_ready", 128'(o_m1_ready), 128'(1'b0));
        check_eq("stale_m0_rdata", o_m0_rdata, '0);
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
        check_eq("stale_busy", 128'(o_busy), 128'(1'b0));

        // timeout at 8 BUSY cycles, then normal completion
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0C00;
        push_txn(1'b1, 1'b0, 32'h0000_0C00, '0, {4{32'hC0FF_EE00}});
        tick();
        repeat (7) tick();
        check_eq("to_before", 128'(o_terr), 128'(1'b0));
        tick();
        check_eq("to_set", 128'(o_terr), 128'(1'b1));
        check_eq("to_still_req", 128'(o_mem_req), 128'(1'b1));
        repeat (3) tick();
        check_eq("to_sticky", 128'(o_terr), 128'(1'b1));
        serve(0, {4{32'hC0FF_EE00}});
        check_eq("to_after_done", 128'(o_terr), 128'(1'b1));

        // fixed priority: port 1 keeps winning while port 0 waits
        sel = 1'b1;
        do_reset();
        check_eq("p1_rst_terr", 128'(o_terr), 128'(1'b0));
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_3000;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_4000;
        push_txn(1'b1, 1'b0, 32'h0000_4000, '0, {4{32'h0000_4000}});
        serve(12, {4{32'h0000_4000}});
        check_eq("p1_no_timeout", 128'(o_terr), 128'(1'b0));
        for (int r = 1; r <= 3; r++) begin
            m1_req = 1'b1;
            m1_addr = 32'h0000_4000 + 32'(r * 16);
            push_txn(1'b1, 1'b0, m1_addr, '0, {4{m1_addr}});
            tick();
            check_eq("p1_wins", 128'(o_grant_id), 128'(1'b1));
            serve(1, {4{m1_addr}});
        end
        push_txn(1'b0, 1'b0, 32'h0000_3000, '0, {4{32'h3333_0000}});
        serve(2, {4{32'h3333_0000}});

        tick();
        check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
